// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART TX scheduler
package uart_pkg;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_LOAD = 3'd2,
        S_WAIT = 3'd3,
        S_NEXT = 3'd4
    } state_t;

    // Line timing of the attached 8N1 transmitter
    localparam int CLK_PER_BIT    = 5000;
    localparam int BITS_PER_FRAME = 10;
    // Slack on top of one full frame before the watchdog fires
    localparam int TMO_MARGIN     = 10000;

    // Increment a round-robin index, wrapping at n
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester and UART TX handshake bundle
interface uart_tx_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int LEN_W = 4
);
    // requester side
    logic [N_REQ-1:0]       req;
    logic [N_REQ*LEN_W-1:0] req_len;
    logic [N_REQ*DW-1:0]    req_data;
    logic [N_REQ-1:0]       req_ack;
    logic [N_REQ-1:0]       grant;
    // transmitter side
    logic [DW-1:0]          tx_data;
    logic                   tx_start;
    logic                   tx_busy;
    logic                   tx_done;
    // status
    logic                   busy;
    logic                   err;

    // scheduler view
    modport master (
        input  req, req_len, req_data, tx_busy, tx_done,
        output req_ack, grant, tx_data, tx_start, busy, err
    );

    // requesters plus UART engine view
    modport slave (
        output req, req_len, req_data, tx_busy, tx_done,
        input  req_ack, grant, tx_data, tx_start, busy, err
    );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-priority pick of the first request at or after rr_ptr
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] win,
    output logic             valid
);

    // one spare bit so rr_ptr + k never overflows before the modulo fold
    logic [IW:0] pos;

    // Scan N_REQ slots starting at rr_ptr; the first set request wins
    always_comb begin
        win   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, rr_ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N_REQ)) begin
                pos = pos - (IW+1)'(N_REQ);
            end
            if (!valid && req[pos[IW-1:0]]) begin
                win[pos[IW-1:0]] = 1'b1;
                valid            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin burst scheduler in front of one UART transmitter
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int LEN_W = 4,
    parameter int TMO   = CLK_PER_BIT * BITS_PER_FRAME + TMO_MARGIN
) (
    input  logic               clk,
    input  logic               res,
    uart_tx_scheduler_if.master bus
);

    localparam int IW = $clog2(N_REQ);
    localparam int WW = $clog2(TMO);

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [IW-1:0]      win_q, win_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [WW-1:0]      wdog_q, wdog_d;
    logic [DW-1:0]      tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic [N_REQ-1:0]   pick_win;
    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic [LEN_W-1:0]   pick_len;
    logic               win_req;
    logic [DW-1:0]      win_data;
    logic [IW-1:0]      next_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req    (bus.req),
        .rr_ptr (rr_q),
        .win    (pick_win),
        .valid  (pick_valid)
    );

    // Decode the arbitration winner and the current owner's request lines
    always_comb begin
        pick_idx = '0;
        pick_len = '0;
        win_req  = 1'b0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_win[i]) begin
                pick_idx = IW'(i);
                pick_len = bus.req_len[i*LEN_W +: LEN_W];
            end
            if (win_q == IW'(i)) begin
                win_req  = bus.req[i];
                win_data = bus.req_data[i*DW +: DW];
            end
        end
        next_ptr = IW'(wrap_inc(32'(win_q), N_REQ));
    end

    // Next-state and next-output logic of the burst sequencer
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        win_d      = win_q;
        rr_d       = rr_q;
        rem_d      = rem_q;
        wdog_d     = wdog_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        ack_d      = '0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                // the request may have been withdrawn while we moved here
                if (pick_valid) begin
                    grant_d = pick_win;
                    win_d   = pick_idx;
                    rem_d   = (pick_len == '0) ? LEN_W'(1) : pick_len;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (!bus.tx_busy) begin
                    tx_data_d  = win_data;
                    tx_start_d = 1'b1;
                    ack_d      = grant_q;
                    rem_d      = rem_q - LEN_W'(1);
                    wdog_d     = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // tx_done takes priority over a coincident watchdog expiry
                if (bus.tx_done) begin
                    state_d = S_NEXT;
                end else if (wdog_q == WW'(TMO - 1)) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    rr_d    = next_ptr;
                    state_d = S_IDLE;
                end else if (wdog_q != '1) begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            S_NEXT: begin
                if (rem_q != '0 && win_req) begin
                    state_d = S_LOAD;
                end else begin
                    grant_d = '0;
                    rr_d    = next_ptr;
                    state_d = S_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, counters and registered outputs; reset aborts any burst at once
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            win_q      <= '0;
            rr_q       <= '0;
            rem_q      <= '0;
            wdog_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            win_q      <= win_d;
            rr_q       <= rr_d;
            rem_q      <= rem_d;
            wdog_q     <= wdog_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.req_ack  = ack_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - randomized bench with 8N1 UART model and scheduler reference model
module tb_uart_tx_scheduler;

    localparam int N   = 4;
    localparam int CPB = 8;
    localparam int TMO = 200;

    logic clk;
    logic res;

    uart_tx_scheduler_if #(.N_REQ(N), .DW(8), .LEN_W(4)) bus ();

    uart_tx_scheduler #(.N_REQ(N), .DW(8), .LEN_W(4), .TMO(TMO)) dut (
        .clk (clk),
        .res (res),
        .bus (bus.master)
    );

    int total = 0;
    int bad   = 0;

    // requester programming (written by main only)
    int          len_a  [N];
    int          need_a [N];
    logic [7:0]  data_a [N][16];
    logic [3:0]  want = '0;
    int          gen  = 0;
    int          model_rr = 0;
    bit          hang = 0;
    bit          busy_hold = 0;
    int          first_ev_cyc = 0;
    int          first_gr_cyc = 0;

    // requester driver state
    int          ackc [N];
    int          seen = 0;
    int          rise_cyc = 0;

    // monitor state
    int          cyc = 0;
    int          viol = 0;
    int          ev_w [$];
    int          ev_d [$];
    int          ev_c [$];
    int          gr_q [$];

    // UART model and receiver state
    bit          uart_active = 0;
    logic        line = 1'b1;
    logic [8:0]  rx_q [$];

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Requesters: assert want bits, advance data on ack, drop after need acks
    initial begin
        logic [3:0] r;
        bus.req = '0;
        bus.req_len = '0;
        bus.req_data = '0;
        for (int i = 0; i < N; i++) ackc[i] = 0;
        forever begin
            @(negedge clk);
            if (gen != seen) begin
                seen = gen;
                rise_cyc = cyc;
                for (int i = 0; i < N; i++) ackc[i] = 0;
            end else begin
                for (int i = 0; i < N; i++) if (bus.req_ack[i]) ackc[i]++;
            end
            for (int i = 0; i < N; i++) begin
                r[i] = want[i] && (ackc[i] < need_a[i]);
                bus.req_len[i*4 +: 4] = 4'(len_a[i]);
                bus.req_data[i*8 +: 8] = data_a[i][(ackc[i] > 15) ? 15 : ackc[i]];
            end
            bus.req = r;
        end
    end

    // Monitor: log every tx_start, grant rises and handshake invariants
    initial begin
        int gi;
        logic [3:0] prev_g;
        prev_g = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            gi = -1;
            for (int i = 0; i < N; i++) if (bus.grant[i]) gi = i;
            if (bus.tx_start) begin
                ev_w.push_back(gi);
                ev_d.push_back(int'(bus.tx_data));
                ev_c.push_back(cyc);
            end
            if (bus.grant != '0 && prev_g == '0) gr_q.push_back(cyc);
            prev_g = bus.grant;
            if ($countones(bus.req_ack) > 1) viol++;
            if ($countones(bus.grant) > 1) viol++;
            if ((bus.req_ack != '0) != bus.tx_start) viol++;
            if (bus.tx_start && bus.req_ack != bus.grant) viol++;
            if (!bus.busy && bus.grant != '0) viol++;
        end
    end

    // 8N1 transmitter model: frame of 10*CPB cycles, tx_done pulse at end of stop bit
    initial begin
        logic [9:0] frame;
        int ucyc;
        frame = '1;
        ucyc = 0;
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_done = 1'b0;
            if (uart_active) begin
                ucyc++;
                if (ucyc == 10 * CPB) begin
                    uart_active = 0;
                    bus.tx_done = 1'b1;
                end
            end else if (bus.tx_start && !hang) begin
                frame = {1'b1, bus.tx_data, 1'b0};
                uart_active = 1;
                ucyc = 0;
            end
            line = uart_active ? frame[ucyc / CPB] : 1'b1;
            bus.tx_busy = uart_active | busy_hold;
        end
    end

    // Serial receiver: mid-bit sampling of the line, logs {stop, byte}
    initial begin
        logic [7:0] b;
        forever begin
            @(posedge clk);
            #3;
            if (line == 1'b0) begin
                repeat (CPB / 2) @(posedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(posedge clk);
                    #3;
                    b[k] = line;
                end
                repeat (CPB) @(posedge clk);
                #3;
                rx_q.push_back({line, b});
            end
        end
    end

    // One scheduling episode: reference order from rr rules, then compare bus events and serial bytes
    task automatic run_round(input logic [3:0] mask, input bit hang_first, input int hold);
        int exp_w [$];
        int exp_d [$];
        int p, w, n, eff, si, eb, rb, gb, budget, errs, err_cyc, rel_cyc, ri;
        si = int'(mask);
        p = model_rr;
        while (si != 0) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && ((si >> ((p + k) % N)) & 1) == 1) w = (p + k) % N;
            eff = (len_a[w] == 0) ? 1 : len_a[w];
            n = (eff < need_a[w]) ? eff : need_a[w];
            if (hang_first && exp_w.size() == 0) n = 1;
            for (int j = 0; j < n; j++) begin
                exp_w.push_back(w);
                exp_d.push_back(int'(data_a[w][j]));
            end
            si = si & ~(1 << w);
            p = (w + 1) % N;
        end
        model_rr = p;
        eb = ev_w.size();
        rb = rx_q.size();
        gb = gr_q.size();
        errs = 0;
        err_cyc = 0;
        rel_cyc = 0;
        hang = hang_first;
        busy_hold = (hold > 0);
        want = mask;
        gen++;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #2;
            chk("hold_no_start", ev_w.size() - eb, 0);
            chk("hold_grant", bus.grant, 1 << exp_w[0]);
            rel_cyc = cyc;
            busy_hold = 0;
        end
        budget = (exp_w.size() + 2) * 150 + 2 * TMO;
        while (budget > 0 && !((ev_w.size() - eb) >= exp_w.size() && !bus.busy && !uart_active)) begin
            @(posedge clk);
            #2;
            budget--;
            if (bus.err) begin
                errs++;
                err_cyc = cyc;
                hang = 0;
            end
        end
        repeat (4) @(posedge clk);
        #2;
        chk("round_done_in_time", budget > 0, 1);
        chk("ev_count", ev_w.size() - eb, exp_w.size());
        ri = rb;
        for (int k = 0; k < exp_w.size(); k++) begin
            if (eb + k < ev_w.size()) begin
                chk("ev_grant", ev_w[eb + k], exp_w[k]);
                chk("ev_data", ev_d[eb + k], exp_d[k]);
            end
            if (!(hang_first && k == 0)) begin
                if (ri < rx_q.size()) begin
                    chk("rx_data", rx_q[ri][7:0], exp_d[k]);
                    chk("rx_stop", rx_q[ri][8], 1);
                end else begin
                    chk("rx_count", rx_q.size(), ri + 1);
                end
                ri++;
            end
        end
        chk("err_count", errs, hang_first ? 1 : 0);
        if (hang_first && ev_c.size() > eb) chk("wdog_latency", err_cyc - ev_c[eb], TMO);
        if (hold > 0 && ev_c.size() > eb)
            chk("hold_release", (ev_c[eb] > rel_cyc && ev_c[eb] <= rel_cyc + 3), 1);
        chk("end_busy", bus.busy, 0);
        chk("end_grant", bus.grant, 0);
        first_ev_cyc = (ev_c.size() > eb) ? ev_c[eb] : -1;
        first_gr_cyc = (gr_q.size() > gb) ? gr_q[gb] : -1;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 16; j++) data_a[i][j] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int eb, budget;
        logic [3:0] m;
        for (int i = 0; i < N; i++) begin
            len_a[i] = 1;
            need_a[i] = 1;
        end
        randomize_data();
        res = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outs", {bus.grant, bus.req_ack, bus.tx_start, bus.busy, bus.err, bus.tx_data}, 0);
        @(negedge clk);
        res = 1'b0;
        repeat (3) @(posedge clk);

        // single burst from requester 0
        len_a[0] = 3;
        need_a[0] = 3;
        data_a[0][0] = 8'h09;
        data_a[0][1] = 8'h06;
        data_a[0][2] = 8'h0A;
        run_round(4'b0001, 0, 0);
        chk("t1_acks", ackc[0], 3);
        chk("t1_lat_grant", first_gr_cyc - rise_cyc, 2);
        chk("t1_lat_start", first_ev_cyc - rise_cyc, 3);

        // len=0 with transmitter busy at LOAD
        randomize_data();
        len_a[1] = 0;
        need_a[1] = 1;
        run_round(4'b0010, 0, 20);
        chk("t6_acks", ackc[1], 1);

        // requester drops after the 2nd ack of a 5-byte burst
        len_a[2] = 5;
        need_a[2] = 2;
        run_round(4'b0100, 0, 0);
        chk("t3_acks", ackc[2], 2);

        // watchdog abort, next requester then served
        randomize_data();
        for (int i = 0; i < N; i++) begin
            len_a[i] = 1;
            need_a[i] = 1;
        end
        run_round(4'b0110, 1, 0);

        // reset in the middle of the 2nd byte of a burst
        eb = ev_w.size();
        len_a[2] = 4;
        need_a[2] = 4;
        want = 4'b0100;
        gen++;
        budget = 1000;
        while (budget > 0 && (ev_w.size() - eb) < 2) begin
            @(posedge clk);
            #2;
            budget--;
        end
        chk("t5_reach_2nd_byte", budget > 0, 1);
        repeat (5) @(posedge clk);
        #2;
        res = 1'b1;
        #1;
        chk("t5_outs_zero", {bus.grant, bus.req_ack, bus.tx_start, bus.busy, bus.err, bus.tx_data}, 0);
        want = '0;
        gen++;
        budget = 500;
        while (budget > 0 && uart_active) begin
            @(posedge clk);
            #2;
            budget--;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        res = 1'b0;
        model_rr = 0;
        chk("t5_no_more_start", ev_w.size() - eb, 2);
        len_a[2] = 1;
        need_a[2] = 1;

        // round-robin, two full rounds from index 0
        run_round(4'b1111, 0, 0);
        randomize_data();
        run_round(4'b1111, 0, 0);

        // randomized episodes
        for (int r = 0; r < 6; r++) begin
            randomize_data();
            for (int i = 0; i < N; i++) begin
                len_a[i] = $urandom_range(0, 3);
                need_a[i] = (len_a[i] == 0) ? 1 : len_a[i];
            end
            m = 4'($urandom_range(1, 15));
            run_round(m, 0, 0);
        end

        chk("handshake_invariants", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
